// File: rtl/sc_bitstream_decoder_if.sv
// Handshake bundle between a stochastic MAC stream source and the bitstream decoder.
interface sc_bitstream_decoder_if #(
  parameter int CNT_WIDTH = 7
);
  logic                 start;
  logic                 sn;
  logic                 sn_valid;
  logic                 busy;
  logic [CNT_WIDTH-1:0] phase;
  logic                 done;
  logic [CNT_WIDTH:0]   result;

  modport master (
    output start, sn, sn_valid,
    input  busy, phase, done, result
  );

  modport slave (
    input  start, sn, sn_valid,
    output busy, phase, done, result
  );
endinterface

// File: rtl/sc_bitstream_decoder.sv
// Stochastic bitstream decoder: counts ones over a window of 2^CNT_WIDTH valid samples
// and reports either the unipolar count or the saturated bipolar value.
module sc_bitstream_decoder #(
  parameter int CNT_WIDTH = 7,
  parameter bit BIPOLAR   = 1'b0
) (
  input logic                   clk,
  input logic                   rst,
  sc_bitstream_decoder_if.slave bus
);
  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_PHASE = '1;
  localparam logic [CNT_WIDTH-1:0] PHASE_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH:0]   WINDOW     = {1'b1, {CNT_WIDTH{1'b0}}};
  localparam logic [CNT_WIDTH:0]   MAX_POS    = {1'b0, {CNT_WIDTH{1'b1}}};

  state_t               state, state_next;
  logic [CNT_WIDTH:0]   acc, acc_next;
  logic [CNT_WIDTH-1:0] phase, phase_next;
  logic                 done, done_next;
  logic [CNT_WIDTH:0]   result, result_next;
  logic [CNT_WIDTH:0]   ones;
  logic [CNT_WIDTH+1:0] twice;
  logic [CNT_WIDTH:0]   result_f;

  // sn is masked by sn_valid so an undriven sn during stalls cannot reach acc
  assign ones = acc + {{CNT_WIDTH{1'b0}}, bus.sn_valid & bus.sn};

  always_comb begin
    twice    = {ones, 1'b0} - {1'b0, WINDOW};
    result_f = ones;
    if (BIPOLAR) begin
      // only ones == window lands at +2^CNT_WIDTH, which does not fit the signed result
      result_f = (!twice[CNT_WIDTH+1] && twice[CNT_WIDTH]) ? MAX_POS : twice[CNT_WIDTH:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      phase  <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      state  <= state_next;
      acc    <= acc_next;
      phase  <= phase_next;
      done   <= done_next;
      result <= result_next;
    end
  end

  always_comb begin
    state_next  = state;
    acc_next    = acc;
    phase_next  = phase;
    done_next   = 1'b0;
    result_next = result;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = ACCUM;
          acc_next   = '0;
          phase_next = '0;
        end
      end
      ACCUM: begin
        if (bus.sn_valid) begin
          if (phase == LAST_PHASE) begin
            result_next = result_f;
            done_next   = 1'b1;
            state_next  = IDLE;
            phase_next  = '0;
            acc_next    = '0;
          end else begin
            acc_next   = ones;
            phase_next = phase + PHASE_ONE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy   = (state == ACCUM);
  assign bus.phase  = phase;
  assign bus.done   = done;
  assign bus.result = result;
endmodule

// File: tb/tb_sc_bitstream_decoder.sv
// Bench for sc_bitstream_decoder: unipolar and bipolar instances share one stimulus stream
// and are checked every cycle against a window-counting model plus literal expectations.
module tb_sc_bitstream_decoder;
  localparam int CNT_WIDTH = 7;
  localparam int WIN       = 1 << CNT_WIDTH;
  localparam int RES_MASK  = (1 << (CNT_WIDTH + 1)) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sc_bitstream_decoder_if #(.CNT_WIDTH(CNT_WIDTH)) bus_u ();
  sc_bitstream_decoder_if #(.CNT_WIDTH(CNT_WIDTH)) bus_b ();

  sc_bitstream_decoder #(.CNT_WIDTH(CNT_WIDTH), .BIPOLAR(1'b0)) dut_u (
    .clk(clk), .rst(rst), .bus(bus_u)
  );
  sc_bitstream_decoder #(.CNT_WIDTH(CNT_WIDTH), .BIPOLAR(1'b1)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int done_seen    = 0;
  bit checking     = 1'b0;

  bit m_busy  = 1'b0;
  bit m_done  = 1'b0;
  int m_count = 0;
  int m_ones  = 0;
  int m_res_u = 0;
  int m_res_b = 0;
  int m_dones = 0;

  function automatic int bipolar_of(input int ones);
    int v;
    v = 2 * ones - WIN;
    if (v > WIN - 1) v = WIN - 1;
    return v & RES_MASK;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic v, input logic s);
    @(negedge clk);
    bus_u.start    = st;
    bus_b.start    = st;
    bus_u.sn_valid = v;
    bus_b.sn_valid = v;
    bus_u.sn       = v ? s : 1'bx;
    bus_b.sn       = v ? s : 1'bx;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (bus_u.done) done_seen <= done_seen + 1;

  // Model: a window is just a count of accepted samples; result follows from the ones tally.
  always @(posedge clk) begin
    int cnt;
    int on;
    cnt = m_count;
    on  = m_ones;
    if (rst) begin
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_count <= 0;
      m_ones  <= 0;
      m_res_u <= 0;
      m_res_b <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (bus_u.start) begin
          m_busy  <= 1'b1;
          m_count <= 0;
          m_ones  <= 0;
        end
      end else if (bus_u.sn_valid) begin
        cnt = cnt + 1;
        on  = on + (bus_u.sn ? 1 : 0);
        if (cnt == WIN) begin
          m_done  <= 1'b1;
          m_busy  <= 1'b0;
          m_res_u <= on;
          m_res_b <= bipolar_of(on);
          m_dones <= m_dones + 1;
          m_count <= 0;
          m_ones  <= 0;
        end else begin
          m_count <= cnt;
          m_ones  <= on;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("busy_u",   int'(bus_u.busy),   int'(m_busy));
      checkOutput("busy_b",   int'(bus_b.busy),   int'(m_busy));
      checkOutput("phase_u",  int'(bus_u.phase),  m_count);
      checkOutput("phase_b",  int'(bus_b.phase),  m_count);
      checkOutput("done_u",   int'(bus_u.done),   int'(m_done));
      checkOutput("done_b",   int'(bus_b.done),   int'(m_done));
      checkOutput("result_u", int'(bus_u.result), m_res_u);
      checkOutput("result_b", int'(bus_b.result), m_res_b);
    end
  end

  initial begin
    int start_cyc;
    int dones_before;
    int model_before;
    int budget;

    rst = 1'b1;
    bus_u.start = 1'b0; bus_b.start = 1'b0;
    bus_u.sn_valid = 1'b0; bus_b.sn_valid = 1'b0;
    bus_u.sn = 1'bx; bus_b.sn = 1'bx;
    repeat (3) @(negedge clk);
    checking = 1'b1;
    checkOutput("reset_busy",     int'(bus_u.busy),   0);
    checkOutput("reset_phase",    int'(bus_u.phase),  0);
    checkOutput("reset_done",     int'(bus_u.done),   0);
    checkOutput("reset_result_u", int'(bus_u.result), 0);
    checkOutput("reset_result_b", int'(bus_b.result), 0);
    rst = 1'b0;

    // all ones
    applyStimulus(1'b1, 1'b0, 1'b0);
    start_cyc = cyc;
    for (int i = 0; i < WIN; i++) applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("ones_done",     int'(bus_u.done),   1);
    checkOutput("ones_latency",  cyc - start_cyc,    129);
    checkOutput("ones_result_u", int'(bus_u.result), 128);
    checkOutput("ones_result_b", int'(bus_b.result), 127);

    // all zeros
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < WIN; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("zeros_done",     int'(bus_u.done),   1);
    checkOutput("zeros_busy",     int'(bus_u.busy),   0);
    checkOutput("zeros_result_u", int'(bus_u.result), 0);
    checkOutput("zeros_result_b", int'(bus_b.result), 8'h80);

    // alternating ones/zeros on every other cycle
    applyStimulus(1'b1, 1'b0, 1'b0);
    start_cyc = cyc;
    for (int i = 0; i < 2 * WIN - 1; i++) begin
      applyStimulus(1'b0, (i % 2) == 0, ((i / 2) % 2) == 0);
      if (i == 10) checkOutput("alt_phase", int'(bus_u.phase), 5);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("alt_done",     int'(bus_u.done),   1);
    checkOutput("alt_latency",  cyc - start_cyc,    256);
    checkOutput("alt_result_u", int'(bus_u.result), 64);
    checkOutput("alt_result_b", int'(bus_b.result), 0);

    // start while busy is ignored; start in the done cycle opens the next window
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < WIN; i++) applyStimulus(i == 49, 1'b1, (i % 3) == 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    start_cyc = cyc;
    checkOutput("restart_done",     int'(bus_u.done),   1);
    checkOutput("restart_result_u", int'(bus_u.result), 43);
    checkOutput("restart_result_b", int'(bus_b.result), 214);
    for (int i = 0; i < WIN; i++) applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("restart2_done",     int'(bus_u.done),   1);
    checkOutput("restart2_latency",  cyc - start_cyc,    129);
    checkOutput("restart2_result_u", int'(bus_u.result), 128);

    // reset mid-window discards the partial count
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 70; i++) applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("midrst_phase70", int'(bus_u.phase), 70);
    dones_before = done_seen;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_busy",     int'(bus_u.busy),   0);
    checkOutput("midrst_phase",    int'(bus_u.phase),  0);
    checkOutput("midrst_result_u", int'(bus_u.result), 0);
    checkOutput("midrst_result_b", int'(bus_b.result), 0);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < WIN; i++) applyStimulus(1'b0, 1'b1, i < 40);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_result_u", int'(bus_u.result), 40);
    checkOutput("post_rst_result_b", int'(bus_b.result), 208);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("midrst_done_count", done_seen - dones_before, 1);

    // random back-to-back windows with start held high
    dones_before = done_seen;
    model_before = m_dones;
    budget = 0;
    while ((m_dones - model_before) < 20 && budget < 20000) begin
      applyStimulus(1'b1, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
      budget++;
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("random_windows",     m_dones - model_before,   20);
    checkOutput("random_done_pulses", done_seen - dones_before, 20);

    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
